// File: rtl/mms_stream_sched.sv
// Streaming max/min scheduler: one comparator is reused across a burst of numbers,
// then the extreme value and its position are returned on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for a start with a non-zero count
// ACCUM | accepting numbers, keeping the running extreme
// DONE  | holding the result until downstream consumes it
module mms_stream_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] result_idx,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pos;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_result_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_result_idx;

  logic             w_hs;
  logic             w_better;
  logic             w_take;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0] w_idx_next;

  // The single shared comparator; strict compare so ties keep the earlier number.
  assign w_hs       = in_valid && r_in_ready;
  assign w_better   = r_sel ? (number < r_acc) : (number > r_acc);
  assign w_take     = (r_pos == '0) || w_better;
  assign w_last     = (r_pos == (r_cnt - 1'b1));
  assign w_acc_next = w_take ? number : r_acc;
  assign w_idx_next = w_take ? r_pos : r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_sel          <= 1'b0;
      r_cnt          <= '0;
      r_pos          <= '0;
      r_acc          <= '0;
      r_idx          <= '0;
      r_in_ready     <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (count != '0)) begin
            r_sel      <= select;
            r_cnt      <= count;
            r_pos      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_acc <= w_acc_next;
            r_idx <= w_idx_next;
            r_pos <= r_pos + 1'b1;
            if (w_last) begin
              r_result       <= w_acc_next;
              r_result_idx   <= w_idx_next;
              r_in_ready     <= 1'b0;
              r_result_valid <= 1'b1;
              r_state        <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_in_ready     <= 1'b0;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_idx   = r_result_idx;

endmodule

// File: tb/tb_mms_stream_sched.sv
// Directed bench for mms_stream_sched: a table of bursts with hand-computed
// results, plus sequences for backpressure, ignored commands and reset mid-burst.
module tb_mms_stream_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       select = 1'b0;
  logic [4:0] count = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] number = '0;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic [7:0] result;
  logic [4:0] result_idx;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  mms_stream_sched #(.WIDTH(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .select(select), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .number(number),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .result_idx(result_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            sel;
    logic [4:0]      cnt;
    logic [1:0]      stall;
    logic [30:0][7:0] nums;
    logic [7:0]      exp_res;
    logic [4:0]      exp_idx;
  } vec_t;

  vec_t vecs [0:7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input int id);
    start = 1'b1; select = v.sel; count = v.cnt;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", id), {31'd0, busy}, 32'd1);
    for (int i = 0; i < int'(v.cnt); i++) begin
      for (int s = 0; s < int'(v.stall); s++) begin
        in_valid = 1'b0;
        number = 8'hAA;
        tick();
      end
      in_valid = 1'b1;
      number = v.nums[i];
      tick();
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d result_valid_latency", id), {31'd0, result_valid}, 32'd1);
    chk($sformatf("v%0d result", id), {24'd0, result}, {24'd0, v.exp_res});
    chk($sformatf("v%0d result_idx", id), {27'd0, result_idx}, {27'd0, v.exp_idx});
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk($sformatf("v%0d valid_drop", id), {30'd0, result_valid, busy}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) vecs[k] = '0;
    vecs[0].sel = 0; vecs[0].cnt = 4; vecs[0].stall = 0;
    vecs[0].nums[0] = 12; vecs[0].nums[1] = 200; vecs[0].nums[2] = 7; vecs[0].nums[3] = 200;
    vecs[0].exp_res = 200; vecs[0].exp_idx = 1;
    vecs[1].sel = 1; vecs[1].cnt = 5; vecs[1].stall = 2;
    vecs[1].nums[0] = 50; vecs[1].nums[1] = 3; vecs[1].nums[2] = 99; vecs[1].nums[3] = 3;
    vecs[1].nums[4] = 0;
    vecs[1].exp_res = 0; vecs[1].exp_idx = 4;
    vecs[2].sel = 1; vecs[2].cnt = 1; vecs[2].nums[0] = 255;
    vecs[2].exp_res = 255; vecs[2].exp_idx = 0;
    vecs[3].sel = 0; vecs[3].cnt = 31; vecs[3].nums[30] = 1;
    vecs[3].exp_res = 1; vecs[3].exp_idx = 30;
    vecs[4].sel = 0; vecs[4].cnt = 3;
    vecs[4].nums[0] = 1; vecs[4].nums[1] = 2; vecs[4].nums[2] = 3;
    vecs[4].exp_res = 3; vecs[4].exp_idx = 2;
    vecs[5].sel = 1; vecs[5].cnt = 3;
    vecs[5].nums[0] = 5; vecs[5].nums[1] = 4; vecs[5].nums[2] = 6;
    vecs[5].exp_res = 4; vecs[5].exp_idx = 1;
    vecs[6].sel = 1; vecs[6].cnt = 4; vecs[6].stall = 1;
    vecs[6].nums[0] = 7; vecs[6].nums[1] = 7; vecs[6].nums[2] = 7; vecs[6].nums[3] = 7;
    vecs[6].exp_res = 7; vecs[6].exp_idx = 0;
    vecs[7].sel = 0; vecs[7].cnt = 2;
    vecs[7].nums[0] = 9; vecs[7].nums[1] = 8;
    vecs[7].exp_res = 9; vecs[7].exp_idx = 0;

    tick(); tick();
    rst = 1'b0;
    chk("reset_state", {17'd0, in_ready, result_valid, busy, result, result_idx}, 32'd0);

    // Table bursts run back-to-back: each start lands on the first IDLE cycle.
    for (int k = 0; k < 8; k++) run_burst(vecs[k], k);

    // Backpressure in DONE with start pulses that must be ignored.
    start = 1'b1; select = 1'b0; count = 5'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; number = 8'd5; tick();
    number = 8'd6; tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      start = 1'b1; count = 5'd3;
      tick();
      chk($sformatf("bp_hold%0d", c), {15'd0, in_ready, result_valid, busy, 6'd0, result},
          {15'd0, 1'b0, 1'b1, 1'b1, 6'd0, 8'd6});
      chk($sformatf("bp_idx%0d", c), {27'd0, result_idx}, 32'd1);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    chk("bp_consume", {29'd0, in_ready, result_valid, busy}, 32'd0);
    chk("bp_result_kept", {24'd0, result}, 32'd6);
    tick();
    chk("start_in_done_ignored", {30'd0, in_ready, busy}, 32'd0);

    // count = 0 in IDLE is ignored.
    start = 1'b1; count = 5'd0;
    tick();
    start = 1'b0;
    chk("count0_ignored", {30'd0, in_ready, busy}, 32'd0);
    tick();
    chk("count0_still_idle", {30'd0, in_ready, busy}, 32'd0);

    // Reset mid-burst discards partial data and clears outputs.
    start = 1'b1; select = 1'b0; count = 5'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; number = 8'd200; tick();
    number = 8'd100; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid_burst", {17'd0, in_ready, result_valid, busy, result, result_idx}, 32'd0);
    tick();
    chk("idle_after_reset", {30'd0, in_ready, busy}, 32'd0);
    run_burst(vecs[7], 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mms_stream_sched.md
Name: mms_stream_sched

Overview:
Sequential scheduler that shares one magnitude comparator across a stream of numbers and returns the maximum or minimum of a burst. A start command latches the mode and the burst length. The block then accepts one number per valid/ready handshake and keeps a running extreme value with a single comparator and mux. When the burst ends, it presents the result and the winner's index on a valid/ready output. It sits in front of the max/min selector datapath and lets bursts longer than four numbers reuse one comparator instead of a comparator tree.

Parameters:
WIDTH, 8, bit width of each number and of the result
CNT_W, 5, width of burst length and index; the maximum burst is 2^CNT_W-1 numbers

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle command to begin a burst; honoured only in IDLE
select  input  1  mode latched on start: 0 = maximum, 1 = minimum
count  input  CNT_W  burst length latched on start; a value of 0 is illegal and ignored
in_valid  input  1  number is present on number
in_ready  output  1  block accepts a number this cycle
number  input  WIDTH  unsigned operand
result_valid  output  1  result and result_idx are valid
result_ready  input  1  downstream consumes the result
result  output  WIDTH  extreme value of the burst
result_idx  output  CNT_W  0-based position of the winning number within the burst
busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-burst):
  - state goes to IDLE.
  - in_ready, result_valid, busy, result, result_idx, and the internal accumulator, index and counter all go to 0.
  - A partially accumulated burst is discarded with no output.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0 and busy=0.
  - start=1 with count!=0: latch select and count, clear the position counter, go to ACCUM.
  - start=1 with count=0: ignored, stay in IDLE.
- ACCUM:
  - in_ready=1 and busy=1.
  - A handshake is in_valid && in_ready.
  - First handshake (position 0): accumulator = number, index = 0.
  - Each later handshake compares number with the accumulator as unsigned values.
    - select=0 replaces the accumulator only if number > accumulator.
    - select=1 replaces it only if number < accumulator.
    - On replacement, index = current position.
  - Ties keep the earlier number and its index.
  - The position counter increments on every handshake.
  - On the handshake where position == count-1: the final compare still applies, result and result_idx are registered, and state goes to DONE.
  - Cycles with in_valid=0 are stalls; no state changes.
  - start is ignored in ACCUM.
- DONE:
  - in_ready=0, result_valid=1, busy=1.
  - result and result_idx stay stable until consumed.
  - result_valid && result_ready: go to IDLE and drop result_valid next cycle.
  - result and result_idx keep their last values until the next burst completes.
  - start is ignored in DONE, even in the cycle the result is consumed.
  - A new start is honoured from the first IDLE cycle.
- Latency: result_valid rises on the clock edge that accepts the last number, so it is visible in the cycle after the last handshake.
- Minimum spacing for back-to-back bursts is start → count handshake cycles → 1 DONE cycle (if result_ready=1) → 1 IDLE cycle → next start.
- count=1: the single number is the result, result_idx=0.
- count = 2^CNT_W-1 is legal. The counter must not wrap before the compare with position == count-1.
- Comparison and output width is exactly WIDTH bits, with no sign extension.

Test Plan:
- Max burst: select=0, count=4, numbers 12,200,7,200 with in_valid held high → result=200, result_idx=1 (tie keeps the earlier number); result_valid high in the cycle after the 4th handshake.
- Min burst with stalls: select=1, count=5, numbers 50,3,99,3,0 with in_valid low for 2 cycles between items → result=0, result_idx=4; no handshake is counted during stalls.
- Edge values: select=1, count=1, number=255 → result=255, result_idx=0. Then select=0, count=31, all numbers 0 except position 30 = 1 → result=1, result_idx=30.
- Backpressure and ignored commands: hold result_ready=0 for 3 cycles in DONE with start=1 pulsed → result and result_valid stable and the start is ignored. Assert result_ready → IDLE next cycle. A start with count=0 in IDLE → stays IDLE, busy=0.
- Reset mid-burst: select=0, count=4, accept 2 numbers, assert rst for one cycle → all outputs 0, state IDLE. A new burst with count=2, numbers 9,8 → result=9, result_idx=0 (no stale data).
- Back-to-back bursts: burst A (select=0: 1,2,3 → 3, idx 2) then burst B (select=1: 5,4,6 → 4, idx 1) with result_ready=1 → both results correct; B's start is accepted in the first IDLE cycle.
